// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, latches Program_Mem output and
// hands one instruction at a time to the execute stage, with jump/halt/resume.
module fetch_sequencer #(
   parameter int PC_WIDTH  = 8,
   parameter int DataWidth = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 res_n,
   output logic [PC_WIDTH-1:0]  pc_o,
   input  logic [DataWidth-1:0] ir_i,
   output logic [DataWidth-1:0] ir_o,
   output logic                 ir_valid_o,
   input  logic                 exec_done_i,
   input  logic                 jmp_i,
   input  logic [PC_WIDTH-1:0]  jmp_addr_i,
   input  logic                 halt_i,
   input  logic                 resume_i,
   output logic                 halted_o,
   output logic [CNT_WIDTH-1:0] instr_cnt_o
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_LOAD  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t               state_reg;
   logic [PC_WIDTH-1:0]  pc_reg;
   logic [DataWidth-1:0] ir_reg;
   logic                 ir_valid_reg;
   logic                 halted_reg;
   logic [CNT_WIDTH-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!res_n) begin
         state_reg    <= ST_FETCH;
         pc_reg       <= '0;
         ir_reg       <= '0;
         ir_valid_reg <= 1'b0;
         halted_reg   <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         case (state_reg)
            // Program_Mem captures mem[pc_o] on this edge; nothing to do here.
            ST_FETCH: state_reg <= ST_LOAD;
            ST_LOAD: begin
               ir_reg       <= ir_i;
               ir_valid_reg <= 1'b1;
               state_reg    <= ST_EXEC;
            end
            ST_EXEC: begin
               if (exec_done_i) begin
                  cnt_reg      <= cnt_reg + 1'b1;
                  ir_valid_reg <= 1'b0;
                  // Natural overflow of pc_reg + 1 gives the wrap to 0.
                  pc_reg       <= jmp_i ? jmp_addr_i : pc_reg + 1'b1;
                  if (halt_i) begin
                     halted_reg <= 1'b1;
                     state_reg  <= ST_HALT;
                  end else begin
                     state_reg  <= ST_FETCH;
                  end
               end
            end
            ST_HALT: begin
               if (resume_i) begin
                  halted_reg <= 1'b0;
                  state_reg  <= ST_FETCH;
               end
            end
            default: state_reg <= ST_FETCH;
         endcase
      end
   end

   assign pc_o        = pc_reg;
   assign ir_o        = ir_reg;
   assign ir_valid_o  = ir_valid_reg;
   assign halted_o    = halted_reg;
   assign instr_cnt_o = cnt_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer with a behavioural Program_Mem; a monitor pops the
// expected {pc, ir} queue each time a new instruction is presented.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        res_n;
   logic [7:0]  pc_o;
   logic [15:0] ir_i;
   logic [15:0] ir_o;
   logic        ir_valid_o;
   logic        exec_done_i;
   logic        jmp_i;
   logic [7:0]  jmp_addr_i;
   logic        halt_i;
   logic        resume_i;
   logic        halted_o;
   logic [15:0] instr_cnt_o;

   int n_vec = 0;
   int n_err = 0;
   logic [23:0] exp_q[$];
   logic        prev_valid = 1'b0;
   logic [15:0] mem [256];

   always #5 clk = ~clk;

   fetch_sequencer #(.PC_WIDTH(8), .DataWidth(16), .CNT_WIDTH(16)) dut (
      .clk         (clk),
      .res_n       (res_n),
      .pc_o        (pc_o),
      .ir_i        (ir_i),
      .ir_o        (ir_o),
      .ir_valid_o  (ir_valid_o),
      .exec_done_i (exec_done_i),
      .jmp_i       (jmp_i),
      .jmp_addr_i  (jmp_addr_i),
      .halt_i      (halt_i),
      .resume_i    (resume_i),
      .halted_o    (halted_o),
      .instr_cnt_o (instr_cnt_o)
   );

   // Program_Mem: registered read of mem[pc]
   always @(posedge clk) ir_i <= mem[pc_o];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
      mem[0]  = 16'b0100_1001_0000_0011;
      mem[1]  = 16'b0100_1010_0001_0100;
      mem[2]  = 16'b0100_1011_1111_0000;
      mem[3]  = 16'b0000_1001_0001_0000;
      mem[4]  = 16'b0001_1001_0001_1000;
      mem[8]  = 16'b0011_0011_0000_1000;
      mem[14] = 16'b1000_0000_0000_1000;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one pop per new presentation of an instruction.
   always @(negedge clk) begin
      if (ir_valid_o && !prev_valid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_instr: got pc=%0h ir=%0h expected none", pc_o, ir_o);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            if ({pc_o, ir_o} !== e) begin
               n_err++;
               $display("FAIL instr: got pc=%0h ir=%0h expected pc=%0h ir=%0h",
                        pc_o, ir_o, e[23:16], e[15:0]);
            end else begin
               $display("instr pc=%0h ir=%0h cnt=%0d", pc_o, ir_o, instr_cnt_o);
            end
         end
      end
      prev_valid = ir_valid_o;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_instr(input logic [7:0] pc);
      exp_q.push_back({pc, mem[pc]});
   endtask

   initial begin
      res_n = 1'b0; exec_done_i = 1'b0; jmp_i = 1'b0; jmp_addr_i = 8'h00;
      halt_i = 1'b0; resume_i = 1'b0;

      // 1 reset and first fetch
      repeat (4) tick();
      check("rst_pc", 32'(pc_o), 32'h0);
      check("rst_valid", 32'(ir_valid_o), 32'h0);
      check("rst_ir", 32'(ir_o), 32'h0);
      check("rst_cnt", 32'(instr_cnt_o), 32'h0);
      check("rst_halted", 32'(halted_o), 32'h0);
      expect_instr(8'd0);
      res_n = 1'b1;
      tick(); tick();
      check("first_valid", 32'(ir_valid_o), 32'h1);
      check("first_ir", 32'(ir_o), 32'h4903);

      // 2 straight-line, done held high
      expect_instr(8'd1); expect_instr(8'd2);
      exec_done_i = 1'b1;
      tick();
      check("pc0_retire_valid", 32'(ir_valid_o), 32'h0);
      tick(); tick();
      check("pc1_ir", 32'(ir_o), 32'h4A14);
      tick(); tick(); tick();
      check("pc2_ir", 32'(ir_o), 32'h4BF0);
      tick();
      check("cnt_after3", 32'(instr_cnt_o), 32'd3);
      check("pc_after3", 32'(pc_o), 32'd3);

      // 3 stall at pc=4
      expect_instr(8'd3);
      tick(); tick(); tick();
      exec_done_i = 1'b0;
      expect_instr(8'd4);
      tick(); tick();
      repeat (10) tick();
      check("stall_pc", 32'(pc_o), 32'd4);
      check("stall_ir", 32'(ir_o), 32'h1918);
      check("stall_valid", 32'(ir_valid_o), 32'h1);
      check("stall_cnt", 32'(instr_cnt_o), 32'd4);
      exec_done_i = 1'b1;
      tick();
      exec_done_i = 1'b0;
      check("stall_done_pc", 32'(pc_o), 32'd5);
      check("stall_done_cnt", 32'(instr_cnt_o), 32'd5);

      // 4 jumps: jmp without done ignored, then to 14, then 14 -> 8
      expect_instr(8'd5);
      tick(); tick();
      jmp_i = 1'b1; jmp_addr_i = 8'd8;
      repeat (3) tick();
      check("jmp_nodone_pc", 32'(pc_o), 32'd5);
      check("jmp_nodone_valid", 32'(ir_valid_o), 32'h1);
      exec_done_i = 1'b1; jmp_addr_i = 8'd14;
      tick();
      exec_done_i = 1'b0; jmp_i = 1'b0;
      check("jmp14_pc", 32'(pc_o), 32'd14);
      expect_instr(8'd14);
      tick(); tick();
      check("pc14_ir", 32'(ir_o), 32'h8008);
      exec_done_i = 1'b1; jmp_i = 1'b1; jmp_addr_i = 8'd8;
      tick();
      exec_done_i = 1'b0; jmp_i = 1'b0;
      check("jmp8_pc", 32'(pc_o), 32'd8);
      check("jmp8_cnt", 32'(instr_cnt_o), 32'd7);
      expect_instr(8'd8);
      tick(); tick();
      check("pc8_ir", 32'(ir_o), 32'h3308);

      // 5 halt + jump, then resume
      exec_done_i = 1'b1; halt_i = 1'b1; jmp_i = 1'b1; jmp_addr_i = 8'd3;
      tick();
      halt_i = 1'b0; jmp_addr_i = 8'h77;
      check("halt_flag", 32'(halted_o), 32'h1);
      check("halt_pc", 32'(pc_o), 32'd3);
      check("halt_valid", 32'(ir_valid_o), 32'h0);
      repeat (20) tick();
      check("halt_hold_flag", 32'(halted_o), 32'h1);
      check("halt_hold_pc", 32'(pc_o), 32'd3);
      check("halt_hold_ir", 32'(ir_o), 32'h3308);
      check("halt_hold_cnt", 32'(instr_cnt_o), 32'd8);
      exec_done_i = 1'b0; jmp_i = 1'b0;
      expect_instr(8'd3);
      resume_i = 1'b1;
      tick();
      resume_i = 1'b0;
      check("resume_flag", 32'(halted_o), 32'h0);
      tick(); tick();
      check("resume_valid", 32'(ir_valid_o), 32'h1);
      check("resume_ir", 32'(ir_o), 32'h0910);

      // 6 wrap at 255, then reset during LOAD
      exec_done_i = 1'b1; jmp_i = 1'b1; jmp_addr_i = 8'd255;
      tick();
      exec_done_i = 1'b0; jmp_i = 1'b0;
      check("jmp255_pc", 32'(pc_o), 32'd255);
      expect_instr(8'd255);
      tick(); tick();
      exec_done_i = 1'b1;
      tick();
      exec_done_i = 1'b0;
      check("wrap_pc", 32'(pc_o), 32'd0);
      check("wrap_cnt", 32'(instr_cnt_o), 32'd10);
      tick();
      res_n = 1'b0;
      tick();
      check("midrst_pc", 32'(pc_o), 32'h0);
      check("midrst_valid", 32'(ir_valid_o), 32'h0);
      check("midrst_ir", 32'(ir_o), 32'h0);
      check("midrst_cnt", 32'(instr_cnt_o), 32'h0);
      check("midrst_halted", 32'(halted_o), 32'h0);
      res_n = 1'b1;
      expect_instr(8'd0);
      tick(); tick();
      check("restart_ir", 32'(ir_o), 32'h4903);
      tick();

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
